// File: rtl/operand_unit_pkg.sv
// Shared decode for the ID-stage operand unit: opcode/funct constants, operand
// select encodings and small decode helpers used by operand_unit.
package operand_unit_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSw      = 6'h2b;

  localparam logic [5:0] FnJalr    = 6'h09;

  typedef enum logic [1:0] {Op1Zero, Op1Rs, Op1Link} op1_sel_e;
  typedef enum logic [2:0] {Op2Zero, Op2Rt, Op2Zext, Op2Sext, Op2Lui} op2_sel_e;

  // Op1Rs is returned exactly for the opcodes that read rs, so it doubles as
  // the rs-used flag for hazard detection.
  function automatic op1_sel_e dec_op1(input logic [5:0] op, input logic [5:0] funct);
    op1_sel_e sel;
    case (op)
      OpSpecial: sel = (funct == FnJalr) ? Op1Link : Op1Rs;
      OpJal:     sel = Op1Link;
      OpAddiu, OpLui, OpLb, OpLw, OpLbu, OpSb, OpSw, OpAddi, OpAndi, OpOri: sel = Op1Rs;
      default:   sel = Op1Zero;
    endcase
    return sel;
  endfunction

  function automatic op2_sel_e dec_op2(input logic [5:0] op);
    op2_sel_e sel;
    case (op)
      OpLui:                                       sel = Op2Lui;
      OpAndi, OpOri:                               sel = Op2Zext;
      OpAddiu, OpAddi, OpLb, OpLw, OpLbu, OpSb, OpSw: sel = Op2Sext;
      OpSpecial:                                   sel = Op2Rt;
      default:                                     sel = Op2Zero;
    endcase
    return sel;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OpSb) || (op == OpSw);
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OpSpecial) || is_store(op);
  endfunction

endpackage

// File: rtl/operand_unit_if.sv
// ID/EX bus for operand_unit: decode fields, register-file values, forwarding
// sources and the EX-side slot handshake.
//   master: decode/forwarding/EX environment (drives id_*, rf_*, fwd_*, ex_ready, flush)
//   slave:  operand_unit (drives id_ready, ex_*, stall_count)
interface operand_unit_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned FWD_SRCS    = 3,
  parameter int unsigned STALL_CNT_W = 16
);
  logic                           flush;
  logic                           id_valid;
  logic                           id_ready;
  logic [ADDR_WIDTH-1:0]          id_addr;
  logic [5:0]                     id_op;
  logic [5:0]                     id_funct;
  logic [15:0]                    id_imm;
  logic [REG_AW-1:0]              id_rs;
  logic [REG_AW-1:0]              id_rt;
  logic [DATA_WIDTH-1:0]          rf_data_1;
  logic [DATA_WIDTH-1:0]          rf_data_2;
  logic [FWD_SRCS-1:0]            fwd_we;
  logic [FWD_SRCS-1:0]            fwd_pending;
  logic [FWD_SRCS*REG_AW-1:0]     fwd_addr;
  logic [FWD_SRCS*DATA_WIDTH-1:0] fwd_data;
  logic                           ex_valid;
  logic                           ex_ready;
  logic [DATA_WIDTH-1:0]          ex_operand_1;
  logic [DATA_WIDTH-1:0]          ex_operand_2;
  logic [DATA_WIDTH-1:0]          ex_store_data;
  logic [STALL_CNT_W-1:0]         stall_count;

  modport master (
    output flush, id_valid, id_addr, id_op, id_funct, id_imm, id_rs, id_rt,
           rf_data_1, rf_data_2, fwd_we, fwd_pending, fwd_addr, fwd_data, ex_ready,
    input  id_ready, ex_valid, ex_operand_1, ex_operand_2, ex_store_data, stall_count
  );

  modport slave (
    input  flush, id_valid, id_addr, id_op, id_funct, id_imm, id_rs, id_rt,
           rf_data_1, rf_data_2, fwd_we, fwd_pending, fwd_addr, fwd_data, ex_ready,
    output id_ready, ex_valid, ex_operand_1, ex_operand_2, ex_store_data, stall_count
  );
endinterface

// File: rtl/operand_unit_fwd_resolve.sv
// Priority forwarding match for one source register.
//   idx         register index to resolve (index 0 never matches)
//   rf_data     register-file value, used when no source matches
//   fwd_*       packed forwarding sources, source 0 youngest
//   data        resolved value
//   pending     winning source has not produced its result yet
module operand_unit_fwd_resolve #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_SRCS   = 3
) (
  input  logic [REG_AW-1:0]              idx,
  input  logic [DATA_WIDTH-1:0]          rf_data,
  input  logic [FWD_SRCS-1:0]            fwd_we,
  input  logic [FWD_SRCS-1:0]            fwd_pending,
  input  logic [FWD_SRCS*REG_AW-1:0]     fwd_addr,
  input  logic [FWD_SRCS*DATA_WIDTH-1:0] fwd_data,
  output logic [DATA_WIDTH-1:0]          data,
  output logic                           pending
);

  // Walk oldest to youngest so the youngest match is the last assignment.
  always_comb begin
    data    = rf_data;
    pending = 1'b0;
    if (idx != '0) begin
      for (int i = FWD_SRCS - 1; i >= 0; i--) begin
        if (fwd_we[i] && (fwd_addr[i*REG_AW +: REG_AW] == idx)) begin
          data    = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
          pending = fwd_pending[i];
        end
      end
    end
  end

endmodule

// File: rtl/operand_unit.sv
// ID-stage operand unit: selects register/immediate/link operands, forwards
// from in-flight writeback sources, interlocks on load-use and holds the
// result in a registered ID/EX slot with a valid/ready handshake.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         operand_unit_if slave: id_* in / id_ready out, rf_* and fwd_* in,
//               ex_ready in / ex_valid, ex_operand_1/2, ex_store_data out,
//               flush in, stall_count out (saturating interlock cycles)
module operand_unit
  import operand_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned FWD_SRCS    = 3,
  parameter int unsigned LINK_OFFSET = 8,
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  operand_unit_if.slave bus
);

  logic [DATA_WIDTH-1:0]  rs_data, rt_data;
  logic                   rs_pending, rt_pending;
  op1_sel_e               op1_sel;
  op2_sel_e               op2_sel;
  logic                   hazard, accept;
  logic [ADDR_WIDTH-1:0]  link_addr;
  logic [31:0]            lui_word;
  logic [DATA_WIDTH-1:0]  op1_d, op2_d, store_d;

  logic                   ex_valid_q;
  logic [DATA_WIDTH-1:0]  op1_q, op2_q, store_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  operand_unit_fwd_resolve #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_AW     (REG_AW),
    .FWD_SRCS   (FWD_SRCS)
  ) u_rs_resolve (
    .idx         (bus.id_rs),
    .rf_data     (bus.rf_data_1),
    .fwd_we      (bus.fwd_we),
    .fwd_pending (bus.fwd_pending),
    .fwd_addr    (bus.fwd_addr),
    .fwd_data    (bus.fwd_data),
    .data        (rs_data),
    .pending     (rs_pending)
  );

  operand_unit_fwd_resolve #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_AW     (REG_AW),
    .FWD_SRCS   (FWD_SRCS)
  ) u_rt_resolve (
    .idx         (bus.id_rt),
    .rf_data     (bus.rf_data_2),
    .fwd_we      (bus.fwd_we),
    .fwd_pending (bus.fwd_pending),
    .fwd_addr    (bus.fwd_addr),
    .fwd_data    (bus.fwd_data),
    .data        (rt_data),
    .pending     (rt_pending)
  );

  assign op1_sel   = dec_op1(bus.id_op, bus.id_funct);
  assign op2_sel   = dec_op2(bus.id_op);
  // Only operands the opcode actually reads can interlock.
  assign hazard    = ((op1_sel == Op1Rs) && rs_pending) || (uses_rt(bus.id_op) && rt_pending);
  assign link_addr = bus.id_addr + ADDR_WIDTH'(LINK_OFFSET);
  assign lui_word  = {bus.id_imm, 16'h0000};

  // rst_n gates id_ready so nothing is accepted while reset is held.
  assign bus.id_ready = rst_n && !hazard && (!ex_valid_q || bus.ex_ready) && !bus.flush;
  assign accept       = bus.id_valid && bus.id_ready;

  always_comb begin
    op1_d = '0;
    case (op1_sel)
      Op1Rs:   op1_d = rs_data;
      Op1Link: op1_d = DATA_WIDTH'(link_addr);
      default: op1_d = '0;
    endcase
  end

  always_comb begin
    op2_d = '0;
    case (op2_sel)
      Op2Lui:  op2_d = DATA_WIDTH'(lui_word);
      Op2Zext: op2_d = DATA_WIDTH'(bus.id_imm);
      Op2Sext: op2_d = DATA_WIDTH'($signed(bus.id_imm));
      Op2Rt:   op2_d = rt_data;
      default: op2_d = '0;
    endcase
  end

  assign store_d = is_store(bus.id_op) ? rt_data : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.id_valid && hazard && !bus.flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Data registers load only on accept; flush and bubbles drop valid only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      store_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (accept) begin
        ex_valid_q <= 1'b1;
        op1_q      <= op1_d;
        op2_q      <= op2_d;
        store_q    <= store_d;
      end else if (bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_operand_1  = op1_q;
  assign bus.ex_operand_2  = op2_q;
  assign bus.ex_store_data = store_q;
  assign bus.stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_operand_unit.sv
module tb_operand_unit;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_ADDU    = 6'h21;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  operand_unit_if #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .REG_AW      (5),
    .FWD_SRCS    (3),
    .STALL_CNT_W (16)
  ) bus ();

  operand_unit #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .REG_AW      (5),
    .FWD_SRCS    (3),
    .LINK_OFFSET (8),
    .STALL_CNT_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the slot is valid it must match the oldest expected
  // entry; the entry retires when EX consumes it.
  always @(negedge clk) begin
    if (rst_n && bus.ex_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL ex_unexpected: got ex_valid=1 op1=0x%08h, expected no slot",
                 bus.ex_operand_1);
      end else begin
        check("ex_operand_1", bus.ex_operand_1, exp_q[0].op1);
        check("ex_operand_2", bus.ex_operand_2, exp_q[0].op2);
        check("ex_store_data", bus.ex_store_data, exp_q[0].st);
        if (bus.ex_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic clr_fwd();
    bus.fwd_we      = '0;
    bus.fwd_pending = '0;
    bus.fwd_addr    = '0;
    bus.fwd_data    = '0;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic [15:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rf1,
                       input logic [31:0] rf2, input logic [31:0] addr);
    bus.id_op     = op;
    bus.id_funct  = funct;
    bus.id_imm    = imm;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.rf_data_1 = rf1;
    bus.rf_data_2 = rf2;
    bus.id_addr   = addr;
    bus.id_valid  = 1'b1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] funct, input logic [15:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rf1,
                       input logic [31:0] rf2, input logic [31:0] addr, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] es);
    bit accepted = 1'b0;
    drive(op, funct, imm, rs, rt, rf1, rf2, addr);
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (bus.id_ready) begin
        exp_q.push_back('{e1, e2, es});
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.id_valid = 1'b0;
    if (!accepted) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got id_ready=0 for 20 cycles, expected acceptance");
    end else begin
      check("latency_ex_valid", bus.ex_valid, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    clr_fwd();
    drive(OP_ORI, 6'h0, 16'h1, 5'd1, 5'd0, 32'h1, 32'h0, 32'h0);

    // Reset held with an instruction offered
    #3;
    check("rst_id_ready", bus.id_ready, 0);
    check("rst_ex_valid", bus.ex_valid, 0);
    check("rst_op1", bus.ex_operand_1, 0);
    check("rst_op2", bus.ex_operand_2, 0);
    check("rst_store", bus.ex_store_data, 0);
    check("rst_stall", bus.stall_count, 0);
    #9;
    bus.id_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_id_ready", bus.id_ready, 1);
    check("post_rst_ex_valid", bus.ex_valid, 0);
    @(posedge clk);
    #1;

    // Immediates
    issue(OP_ORI,   6'h0, 16'h8001, 5'd1, 5'd0, 32'h11, 32'h0, 32'h0, 32'h11, 32'h0000_8001, 0);
    issue(OP_ADDIU, 6'h0, 16'h8001, 5'd2, 5'd0, 32'h22, 32'h0, 32'h0, 32'h22, 32'hFFFF_8001, 0);
    issue(OP_LUI,   6'h0, 16'h1234, 5'd0, 5'd0, 32'h33, 32'h0, 32'h0, 32'h33, 32'h1234_0000, 0);

    // Youngest match wins; disabled source ignored for rt
    bus.fwd_we   = 3'b101;
    bus.fwd_addr = {5'd5, 5'd6, 5'd5};
    bus.fwd_data = {32'hBBBB, 32'h6666, 32'hAAAA};
    issue(OP_SPECIAL, FN_ADDU, 16'h0, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, 32'hAAAA, 32'h2, 0);

    // Register 0 never forwards
    bus.fwd_we   = 3'b111;
    bus.fwd_addr = '0;
    bus.fwd_data = {32'h3, 32'h2, 32'h1};
    issue(OP_ORI, 6'h0, 16'h0005, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 32'h77, 32'h5, 0);

    // Pending older source shadowed by younger ready one: no interlock
    bus.fwd_we      = 3'b011;
    bus.fwd_pending = 3'b010;
    bus.fwd_addr    = {5'd0, 5'd9, 5'd9};
    bus.fwd_data    = {32'h0, 32'h1111, 32'h99};
    issue(OP_SPECIAL, FN_ADDU, 16'h0, 5'd9, 5'd0, 32'h0, 32'h4, 32'h0, 32'h99, 32'h4, 0);
    check("shadow_no_stall", bus.stall_count, 0);

    // Load-use interlock on r7
    bus.fwd_we      = 3'b001;
    bus.fwd_pending = 3'b001;
    bus.fwd_addr    = {5'd0, 5'd0, 5'd7};
    bus.fwd_data    = {32'h0, 32'h0, 32'hDEAD_0000};
    drive(OP_SPECIAL, FN_ADDU, 16'h0, 5'd7, 5'd3, 32'h0, 32'h3, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("lu_id_ready", bus.id_ready, 0);
      @(posedge clk);
      #1;
      check("lu_bubble", bus.ex_valid, 0);
    end
    check("lu_stall_count", bus.stall_count, 2);
    bus.fwd_pending = 3'b000;
    bus.fwd_data    = {32'h0, 32'h0, 32'h7777};
    issue(OP_SPECIAL, FN_ADDU, 16'h0, 5'd7, 5'd3, 32'h0, 32'h3, 32'h0, 32'h7777, 32'h3, 0);
    check("lu_stall_after", bus.stall_count, 2);

    // Links; JALR ignores a pending rs
    clr_fwd();
    issue(OP_JAL, 6'h0, 16'hFFFF, 5'd4, 5'd4, 32'h5, 32'h6, 32'h400, 32'h408, 32'h0, 0);
    bus.fwd_we      = 3'b011;
    bus.fwd_pending = 3'b001;
    bus.fwd_addr    = {5'd0, 5'd10, 5'd11};
    bus.fwd_data    = {32'h0, 32'h55, 32'h0};
    issue(OP_SPECIAL, FN_JALR, 16'h0, 5'd11, 5'd10, 32'h1, 32'h2, 32'h400, 32'h408, 32'h55, 0);
    check("jalr_no_stall", bus.stall_count, 2);

    // Unlisted opcode gives zero operands
    clr_fwd();
    issue(OP_J, 6'h0, 16'h1234, 5'd1, 5'd2, 32'h99, 32'h98, 32'h0, 32'h0, 32'h0, 0);

    // Backpressure: drain, then hold a store while the next one waits
    @(posedge clk);
    #1;
    bus.ex_ready = 1'b0;
    issue(OP_SW, 6'h0, 16'hFFFC, 5'd4, 5'd8, 32'h40, 32'h1234_5678, 32'h0,
          32'h40, 32'hFFFF_FFFC, 32'h1234_5678);
    drive(OP_ORI, 6'h0, 16'h1, 5'd1, 5'd0, 32'h1, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_id_ready", bus.id_ready, 0);
      @(posedge clk);
      #1;
      check("bp_ex_valid", bus.ex_valid, 1);
    end

    // Flush beats both hold and accept
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_id_ready", bus.id_ready, 0);
    @(posedge clk);
    #1;
    check("flush_ex_valid", bus.ex_valid, 0);
    check("flush_data_kept", bus.ex_operand_2, 32'hFFFF_FFFC);
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("final_ex_valid", bus.ex_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
